// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 keyboard receiver.
// Holds the special scan codes, the frame FSM state encoding and the layout
// of the 10-bit event word {extended, release, code[7:0]}.
package ps2_pkg;

  localparam logic [7:0] PS2_BAT_PASS = 8'hAA;
  localparam logic [7:0] PS2_BAT_FAIL = 8'hFC;
  localparam logic [7:0] PS2_EXT      = 8'hE0;
  localparam logic [7:0] PS2_REL      = 8'hF0;

  typedef enum logic [1:0] {
    StIdle,
    StData,
    StParity,
    StStop
  } ps2_state_e;

  localparam int unsigned EVT_W        = 10;
  localparam int unsigned EVT_CODE_LSB = 0;
  localparam int unsigned EVT_CODE_W   = 8;
  localparam int unsigned EVT_REL_BIT  = 8;
  localparam int unsigned EVT_EXT_BIT  = 9;

  function automatic logic [EVT_W-1:0] evt_pack(input logic       ext,
                                                input logic       rel,
                                                input logic [7:0] code);
    logic [EVT_W-1:0] evt;
    evt                                = '0;
    evt[EVT_EXT_BIT]                   = ext;
    evt[EVT_REL_BIT]                   = rel;
    evt[EVT_CODE_LSB +: EVT_CODE_W]    = code;
    return evt;
  endfunction

endpackage

// File: rtl/ps2_event_fifo.sv
// Synchronous event FIFO for decoded key events.
// Ports:
//   i_clk, i_rst_n : clock, asynchronous active-low reset
//   i_push, i_data : write request and word
//   i_pop          : read request (ignored when empty)
//   o_data         : head word, zero when empty
//   o_valid        : FIFO non-empty
//   o_count        : occupancy, 0..DEPTH
//   o_drop         : push rejected this cycle because the FIFO was full
module ps2_event_fifo
  import ps2_pkg::*;
#(
  parameter int unsigned WIDTH = EVT_W,
  parameter int unsigned DEPTH = 8
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_data,
  input  logic                     i_pop,
  output logic [WIDTH-1:0]         o_data,
  output logic                     o_valid,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_drop
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] DepthCnt = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;

  logic w_empty;
  logic w_full;
  logic w_do_pop;
  logic w_do_push;

  assign w_empty   = (r_count == '0);
  assign w_full    = (r_count == DepthCnt);
  assign w_do_pop  = i_pop && !w_empty;
  // A full FIFO still accepts a push when a pop frees a slot in the same cycle.
  assign w_do_push = i_push && (!w_full || w_do_pop);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      if (w_do_push && !w_do_pop)      r_count <= r_count + (AW + 1)'(1);
      else if (w_do_pop && !w_do_push) r_count <= r_count - (AW + 1)'(1);
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_data;
  end

  assign o_data  = w_empty ? '0 : r_mem[r_rd_ptr];
  assign o_valid = !w_empty;
  assign o_count = r_count;
  assign o_drop  = i_push && w_full && !w_do_pop;

endmodule

// File: rtl/ps2_key_receiver.sv
// PS/2 keyboard receiver: synchronises and deglitches the PS/2 lines, frames
// 11-bit words, decodes E0/F0 prefixes and self-test codes, and queues key
// events {extended, release, code} in a FIFO.
// Ports:
//   i_clk, i_rst_n            : system clock, asynchronous active-low reset
//   i_ps2_clk, i_ps2_data     : raw keyboard lines (asynchronous)
//   o_evt_data/valid/count    : FIFO head, non-empty flag, occupancy
//   i_evt_ready               : consumer pop
//   o_bat_pass, o_bat_fail    : self-test result pulses
//   o_parity_err, o_frame_err, o_timeout_err : error pulses
//   o_overflow, i_overflow_clr: sticky dropped-event flag and its clear
module ps2_key_receiver
  import ps2_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH     = 8,
  parameter int unsigned SYNC_STAGES    = 2,
  parameter int unsigned FILTER_LEN     = 8,
  parameter int unsigned TIMEOUT_CYCLES = 50000
) (
  input  logic                          i_clk,
  input  logic                          i_rst_n,
  input  logic                          i_ps2_clk,
  input  logic                          i_ps2_data,
  output logic [EVT_W-1:0]              o_evt_data,
  output logic                          o_evt_valid,
  input  logic                          i_evt_ready,
  output logic [$clog2(FIFO_DEPTH):0]   o_evt_count,
  output logic                          o_bat_pass,
  output logic                          o_bat_fail,
  output logic                          o_parity_err,
  output logic                          o_frame_err,
  output logic                          o_timeout_err,
  output logic                          o_overflow,
  input  logic                          i_overflow_clr
);

  localparam int unsigned FW = $clog2(FILTER_LEN + 1);
  localparam int unsigned GW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [FW-1:0] FiltMax = FW'(FILTER_LEN - 1);
  localparam logic [GW-1:0] GapMax  = GW'(TIMEOUT_CYCLES);

  // Synchronisers and clock deglitch filter
  logic [SYNC_STAGES-1:0] r_clk_sync;
  logic [SYNC_STAGES-1:0] r_data_sync;
  logic                   r_filt_clk;
  logic                   r_filt_prev;
  logic [FW-1:0]          r_filt_cnt;
  logic                   w_clk_s;
  logic                   w_data_s;
  logic                   w_edge;

  assign w_clk_s  = r_clk_sync[SYNC_STAGES-1];
  assign w_data_s = r_data_sync[SYNC_STAGES-1];
  assign w_edge   = r_filt_prev && !r_filt_clk;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_clk_sync  <= '1;
      r_data_sync <= '1;
      r_filt_clk  <= 1'b1;
      r_filt_prev <= 1'b1;
      r_filt_cnt  <= '0;
    end else begin
      r_clk_sync  <= {r_clk_sync[SYNC_STAGES-2:0], i_ps2_clk};
      r_data_sync <= {r_data_sync[SYNC_STAGES-2:0], i_ps2_data};
      r_filt_prev <= r_filt_clk;
      // Count consecutive samples that disagree with the filtered level.
      if (w_clk_s == r_filt_clk) begin
        r_filt_cnt <= '0;
      end else if (r_filt_cnt == FiltMax) begin
        r_filt_clk <= w_clk_s;
        r_filt_cnt <= '0;
      end else begin
        r_filt_cnt <= r_filt_cnt + FW'(1);
      end
    end
  end

  // Frame FSM
  ps2_state_e    r_state;
  ps2_state_e    w_state_next;
  logic [7:0]    r_shift;
  logic [2:0]    r_bit_cnt;
  logic          r_par_bit;
  logic [GW-1:0] r_gap;
  logic          w_timeout;
  logic          w_start;
  logic          w_shift_en;
  logic          w_par_cap;
  logic          w_stop_edge;
  logic          w_idle_ferr;

  assign w_timeout = (r_state != StIdle) && !w_edge && (r_gap == GapMax);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= StIdle;
    else          r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    if (w_timeout) begin
      w_state_next = StIdle;
    end else if (w_edge) begin
      unique case (r_state)
        StIdle:   if (!w_data_s) w_state_next = StData;
        StData:   if (r_bit_cnt == 3'd7) w_state_next = StParity;
        StParity: w_state_next = StStop;
        StStop:   w_state_next = StIdle;
        default:  w_state_next = StIdle;
      endcase
    end
  end

  always_comb begin
    w_start     = 1'b0;
    w_shift_en  = 1'b0;
    w_par_cap   = 1'b0;
    w_stop_edge = 1'b0;
    w_idle_ferr = 1'b0;
    if (w_edge) begin
      unique case (r_state)
        StIdle: begin
          w_start     = !w_data_s;
          w_idle_ferr = w_data_s;
        end
        StData:   w_shift_en  = 1'b1;
        StParity: w_par_cap   = 1'b1;
        StStop:   w_stop_edge = 1'b1;
        default:  ;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_shift   <= '0;
      r_bit_cnt <= '0;
      r_par_bit <= 1'b0;
      r_gap     <= '0;
    end else begin
      if (w_start) r_bit_cnt <= '0;
      if (w_shift_en) begin
        r_shift   <= {w_data_s, r_shift[7:1]};  // LSB arrives first
        r_bit_cnt <= r_bit_cnt + 3'd1;
      end
      if (w_par_cap) r_par_bit <= w_data_s;
      if (w_edge || w_timeout || (r_state == StIdle)) r_gap <= '0;
      else                                            r_gap <= r_gap + GW'(1);
    end
  end

  // Byte check and prefix decode
  logic w_par_ok;
  logic w_parity_err;
  logic w_frame_err;
  logic w_any_err;
  logic w_byte_good;
  logic w_push;
  logic w_bat_pass;
  logic w_bat_fail;
  logic w_drop;
  logic r_ext;
  logic r_rel;

  assign w_par_ok     = ^{r_shift, r_par_bit};
  assign w_parity_err = w_stop_edge && !w_par_ok;
  assign w_frame_err  = w_idle_ferr || (w_stop_edge && !w_data_s);
  assign w_any_err    = w_parity_err || w_frame_err || w_timeout;
  assign w_byte_good  = w_stop_edge && w_par_ok && w_data_s;

  always_comb begin
    w_push     = 1'b0;
    w_bat_pass = 1'b0;
    w_bat_fail = 1'b0;
    if (w_byte_good && (r_shift != PS2_EXT) && (r_shift != PS2_REL)) begin
      // Self-test codes only count as such when no prefix is pending.
      if (!r_ext && !r_rel && (r_shift == PS2_BAT_PASS))      w_bat_pass = 1'b1;
      else if (!r_ext && !r_rel && (r_shift == PS2_BAT_FAIL)) w_bat_fail = 1'b1;
      else                                                    w_push     = 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_ext         <= 1'b0;
      r_rel         <= 1'b0;
      o_bat_pass    <= 1'b0;
      o_bat_fail    <= 1'b0;
      o_parity_err  <= 1'b0;
      o_frame_err   <= 1'b0;
      o_timeout_err <= 1'b0;
      o_overflow    <= 1'b0;
    end else begin
      if (w_any_err || w_push) begin
        r_ext <= 1'b0;
        r_rel <= 1'b0;
      end else if (w_byte_good && (r_shift == PS2_EXT)) begin
        r_ext <= 1'b1;
      end else if (w_byte_good && (r_shift == PS2_REL)) begin
        r_rel <= 1'b1;
      end
      o_bat_pass    <= w_bat_pass;
      o_bat_fail    <= w_bat_fail;
      o_parity_err  <= w_parity_err;
      o_frame_err   <= w_frame_err;
      o_timeout_err <= w_timeout;
      // A new drop wins over a simultaneous clear.
      o_overflow    <= w_drop || (o_overflow && !i_overflow_clr);
    end
  end

  ps2_event_fifo #(
    .WIDTH (EVT_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_push  (w_push),
    .i_data  (evt_pack(r_ext, r_rel, r_shift)),
    .i_pop   (i_evt_ready),
    .o_data  (o_evt_data),
    .o_valid (o_evt_valid),
    .o_count (o_evt_count),
    .o_drop  (w_drop)
  );

endmodule

// File: tb/tb_ps2_key_receiver.sv
module tb_ps2_key_receiver;

  localparam int unsigned FifoDepth = 4;
  localparam int unsigned SyncStages = 2;
  localparam int unsigned FilterLen = 4;
  localparam int unsigned TimeoutCycles = 400;
  localparam int unsigned Half = 30;
  localparam int unsigned CW = $clog2(FifoDepth) + 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          ps2_clk = 1'b1;
  logic          ps2_data = 1'b1;
  logic          evt_ready = 1'b1;
  logic          overflow_clr = 1'b0;
  logic [9:0]    evt_data;
  logic          evt_valid;
  logic [CW-1:0] evt_count;
  logic          bat_pass, bat_fail, parity_err, frame_err, timeout_err, overflow;

  always #5 clk = ~clk;

  ps2_key_receiver #(
    .FIFO_DEPTH     (FifoDepth),
    .SYNC_STAGES    (SyncStages),
    .FILTER_LEN     (FilterLen),
    .TIMEOUT_CYCLES (TimeoutCycles)
  ) dut (
    .i_clk          (clk),
    .i_rst_n        (rst_n),
    .i_ps2_clk      (ps2_clk),
    .i_ps2_data     (ps2_data),
    .o_evt_data     (evt_data),
    .o_evt_valid    (evt_valid),
    .i_evt_ready    (evt_ready),
    .o_evt_count    (evt_count),
    .o_bat_pass     (bat_pass),
    .o_bat_fail     (bat_fail),
    .o_parity_err   (parity_err),
    .o_frame_err    (frame_err),
    .o_timeout_err  (timeout_err),
    .o_overflow     (overflow),
    .i_overflow_clr (overflow_clr)
  );

  int n_checks = 0;
  int n_fail = 0;

  logic [9:0] got_q[$];
  logic [9:0] exp_q[$];
  int mon_bp = 0, mon_bf = 0, mon_par = 0, mon_fr = 0, mon_to = 0, mon_both = 0;
  int exp_bp = 0, exp_bf = 0, exp_par = 0, exp_fr = 0, exp_to = 0, exp_both = 0;
  bit m_ext = 0, m_rel = 0;

  // Observe pops and pulses away from the active edge.
  always @(negedge clk) begin
    if (rst_n) begin
      if (evt_valid && evt_ready) got_q.push_back(evt_data);
      if (bat_pass) mon_bp++;
      if (bat_fail) mon_bf++;
      if (parity_err) mon_par++;
      if (frame_err) mon_fr++;
      if (timeout_err) mon_to++;
      if (parity_err && frame_err) mon_both++;
    end
  end

  // Reference behaviour of one received byte, in terms of protocol rules.
  function automatic void model_byte(input logic [7:0] b, input bit bad_par, input bit bad_stop);
    if (bad_par || bad_stop) begin
      if (bad_par) exp_par++;
      if (bad_stop) exp_fr++;
      if (bad_par && bad_stop) exp_both++;
      m_ext = 0;
      m_rel = 0;
    end else if (b == 8'hE0) begin
      m_ext = 1;
    end else if (b == 8'hF0) begin
      m_rel = 1;
    end else if (!m_ext && !m_rel && b == 8'hAA) begin
      exp_bp++;
    end else if (!m_ext && !m_rel && b == 8'hFC) begin
      exp_bf++;
    end else begin
      exp_q.push_back({m_ext, m_rel, b});
      m_ext = 0;
      m_rel = 0;
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ps2_bit(input logic d);
    ps2_data = d;
    repeat (Half) tick();
    ps2_clk = 1'b0;
    repeat (Half) tick();
    ps2_clk = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop);
    logic [10:0] bits;
    bits = {~bad_stop, (~^b) ^ bad_par, b, 1'b0};
    for (int i = 0; i < 11; i++) ps2_bit(bits[i]);
    ps2_data = 1'b1;
    repeat (2 * Half) tick();
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if (evt_valid !== 1'b0 || evt_count !== '0 || evt_data !== '0) begin
      n_fail++;
      $display("FAIL reset_fifo got valid=%b count=%0d data=%h want 0/0/000",
               evt_valid, evt_count, evt_data);
    end
    n_checks++;
    if ({overflow, bat_pass, bat_fail, parity_err, frame_err, timeout_err} !== 6'b0) begin
      n_fail++;
      $display("FAIL reset_flags got %b want 000000",
               {overflow, bat_pass, bat_fail, parity_err, frame_err, timeout_err});
    end
    repeat (3) tick();
    rst_n = 1'b1;
    repeat (5) tick();
  endtask

  task automatic test_single_event();
    logic [10:0] bits;
    int lat;
    evt_ready = 1'b0;
    bits = {1'b1, ~^8'h1C, 8'h1C, 1'b0};
    for (int i = 0; i < 10; i++) ps2_bit(bits[i]);
    ps2_data = 1'b1;
    repeat (Half) tick();
    n_checks++;
    if (evt_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL single_early_valid got %b want 0", evt_valid);
    end
    ps2_clk = 1'b0;
    lat = 0;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (evt_valid && lat == 0) lat = i;
    end
    n_checks++;
    if (lat < SyncStages + 1 || lat > SyncStages + FilterLen + 3) begin
      n_fail++;
      $display("FAIL single_latency got %0d cycles want %0d..%0d",
               lat, SyncStages + 1, SyncStages + FilterLen + 3);
    end
    repeat (Half) tick();
    ps2_clk = 1'b1;
    repeat (2 * Half) tick();
    model_byte(8'h1C, 0, 0);
    n_checks++;
    if (evt_data !== 10'h01C || evt_count !== CW'(1)) begin
      n_fail++;
      $display("FAIL single_head got data=%h count=%0d want 01c/1", evt_data, evt_count);
    end
    evt_ready = 1'b1;
    repeat (3) tick();
    n_checks++;
    if (got_q.size() != 1 || got_q[0] !== exp_q[0]) begin
      n_fail++;
      $display("FAIL single_pop got n=%0d want n=1 data=%h", got_q.size(), exp_q[0]);
    end
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic test_prefix();
    logic [7:0] seq [3];
    seq = '{8'hE0, 8'hF0, 8'h75};
    foreach (seq[i]) begin
      send_frame(seq[i], 0, 0);
      model_byte(seq[i], 0, 0);
      n_checks++;
      if (i < 2 && got_q.size() != 0) begin
        n_fail++;
        $display("FAIL prefix_no_event got %0d events after %h want 0", got_q.size(), seq[i]);
      end
    end
    n_checks++;
    if (got_q.size() != 1 || exp_q.size() != 1 || got_q[0] !== 10'h375) begin
      n_fail++;
      $display("FAIL prefix_event got n=%0d first=%h want n=1 data=375",
               got_q.size(), (got_q.size() > 0) ? got_q[0] : 10'h0);
    end
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic test_parity();
    send_frame(8'h1C, 1, 0);
    model_byte(8'h1C, 1, 0);
    n_checks++;
    if (mon_par !== exp_par || got_q.size() != 0) begin
      n_fail++;
      $display("FAIL parity_err got pulses=%0d events=%0d want pulses=%0d events=0",
               mon_par, got_q.size(), exp_par);
    end
    send_frame(8'hF0, 0, 0);
    model_byte(8'hF0, 0, 0);
    send_frame(8'h1C, 0, 0);
    model_byte(8'h1C, 0, 0);
    n_checks++;
    if (got_q.size() != 1 || got_q[0] !== 10'h11C) begin
      n_fail++;
      $display("FAIL parity_recover got n=%0d first=%h want n=1 data=11c",
               got_q.size(), (got_q.size() > 0) ? got_q[0] : 10'h0);
    end
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic test_frame_errors();
    ps2_data = 1'b1;
    ps2_bit(1'b1);
    repeat (Half) tick();
    exp_fr++;
    m_ext = 0;
    m_rel = 0;
    n_checks++;
    if (mon_fr !== exp_fr) begin
      n_fail++;
      $display("FAIL idle_frame_err got %0d want %0d", mon_fr, exp_fr);
    end
    send_frame(8'h33, 1, 1);
    model_byte(8'h33, 1, 1);
    send_frame(8'h42, 0, 1);
    model_byte(8'h42, 0, 1);
    n_checks++;
    if (mon_fr !== exp_fr || mon_par !== exp_par || mon_both !== exp_both) begin
      n_fail++;
      $display("FAIL stop_errors got fr=%0d par=%0d both=%0d want fr=%0d par=%0d both=%0d",
               mon_fr, mon_par, mon_both, exp_fr, exp_par, exp_both);
    end
    n_checks++;
    if (got_q.size() != 0) begin
      n_fail++;
      $display("FAIL stop_err_discard got %0d events want 0", got_q.size());
    end
    got_q.delete();
  endtask

  task automatic test_timeout();
    ps2_bit(1'b0);
    for (int i = 0; i < 4; i++) ps2_bit(1'b1);
    ps2_data = 1'b1;
    repeat (TimeoutCycles + 60) tick();
    exp_to++;
    m_ext = 0;
    m_rel = 0;
    n_checks++;
    if (mon_to !== exp_to) begin
      n_fail++;
      $display("FAIL timeout_pulse got %0d want %0d", mon_to, exp_to);
    end
    send_frame(8'h29, 0, 0);
    model_byte(8'h29, 0, 0);
    n_checks++;
    if (got_q.size() != 1 || got_q[0] !== 10'h029) begin
      n_fail++;
      $display("FAIL timeout_recover got n=%0d first=%h want n=1 data=029",
               got_q.size(), (got_q.size() > 0) ? got_q[0] : 10'h0);
    end
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic test_bat();
    send_frame(8'hAA, 0, 0);
    model_byte(8'hAA, 0, 0);
    send_frame(8'hFC, 0, 0);
    model_byte(8'hFC, 0, 0);
    n_checks++;
    if (mon_bp !== exp_bp || mon_bf !== exp_bf || got_q.size() != 0) begin
      n_fail++;
      $display("FAIL bat_codes got pass=%0d fail=%0d events=%0d want pass=%0d fail=%0d events=0",
               mon_bp, mon_bf, got_q.size(), exp_bp, exp_bf);
    end
    send_frame(8'hE0, 0, 0);
    model_byte(8'hE0, 0, 0);
    send_frame(8'hAA, 0, 0);
    model_byte(8'hAA, 0, 0);
    n_checks++;
    if (got_q.size() != 1 || got_q[0] !== 10'h2AA || mon_bp !== exp_bp) begin
      n_fail++;
      $display("FAIL bat_prefixed got n=%0d first=%h pass=%0d want n=1 data=2aa pass=%0d",
               got_q.size(), (got_q.size() > 0) ? got_q[0] : 10'h0, mon_bp, exp_bp);
    end
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic test_random();
    logic [7:0] b;
    bit bp;
    int r;
    for (int n = 0; n < 20; n++) begin
      r = $urandom_range(0, 99);
      if (r < 20)      b = 8'hE0;
      else if (r < 35) b = 8'hF0;
      else if (r < 40) b = 8'hAA;
      else if (r < 45) b = 8'hFC;
      else             b = 8'($urandom_range(0, 255));
      bp = ($urandom_range(0, 9) == 0);
      send_frame(b, bp, 0);
      model_byte(b, bp, 0);
    end
    n_checks++;
    if (got_q.size() != exp_q.size()) begin
      n_fail++;
      $display("FAIL random_count got %0d events want %0d", got_q.size(), exp_q.size());
    end else begin
      foreach (exp_q[i]) begin
        n_checks++;
        if (got_q[i] !== exp_q[i]) begin
          n_fail++;
          $display("FAIL random_event[%0d] got %h want %h", i, got_q[i], exp_q[i]);
        end
      end
    end
    n_checks++;
    if (mon_bp !== exp_bp || mon_bf !== exp_bf || mon_par !== exp_par) begin
      n_fail++;
      $display("FAIL random_pulses got bp=%0d bf=%0d par=%0d want bp=%0d bf=%0d par=%0d",
               mon_bp, mon_bf, mon_par, exp_bp, exp_bf, exp_par);
    end
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic test_overflow();
    logic [7:0] c [FifoDepth + 1];
    m_ext = 0;
    m_rel = 0;
    evt_ready = 1'b0;
    foreach (c[i]) begin
      c[i] = 8'($urandom_range(1, 127));
      send_frame(c[i], 0, 0);
    end
    n_checks++;
    if (evt_count !== CW'(FifoDepth) || overflow !== 1'b1) begin
      n_fail++;
      $display("FAIL overflow_full got count=%0d ovf=%b want count=%0d ovf=1",
               evt_count, overflow, FifoDepth);
    end
    n_checks++;
    if (evt_data !== {2'b00, c[0]}) begin
      n_fail++;
      $display("FAIL overflow_head got %h want %h", evt_data, {2'b00, c[0]});
    end
    overflow_clr = 1'b1;
    tick();
    overflow_clr = 1'b0;
    tick();
    n_checks++;
    if (overflow !== 1'b0) begin
      n_fail++;
      $display("FAIL overflow_clear got %b want 0", overflow);
    end
    evt_ready = 1'b1;
    repeat (10) tick();
    n_checks++;
    if (got_q.size() != FifoDepth || evt_count !== '0) begin
      n_fail++;
      $display("FAIL overflow_drain got n=%0d count=%0d want n=%0d count=0",
               got_q.size(), evt_count, FifoDepth);
    end else begin
      for (int i = 0; i < FifoDepth; i++) begin
        n_checks++;
        if (got_q[i] !== {2'b00, c[i]}) begin
          n_fail++;
          $display("FAIL overflow_order[%0d] got %h want %h", i, got_q[i], {2'b00, c[i]});
        end
      end
    end
    got_q.delete();
  endtask

  task automatic test_reset_midframe();
    evt_ready = 1'b0;
    send_frame(8'h44, 0, 0);
    n_checks++;
    if (evt_count !== CW'(1)) begin
      n_fail++;
      $display("FAIL midreset_pre got count=%0d want 1", evt_count);
    end
    ps2_bit(1'b0);
    ps2_bit(1'b1);
    ps2_bit(1'b0);
    ps2_data = 1'b1;
    ps2_clk = 1'b0;
    repeat (10) tick();
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if (evt_count !== '0 || evt_valid !== 1'b0 || evt_data !== '0 || overflow !== 1'b0) begin
      n_fail++;
      $display("FAIL midreset_clear got count=%0d valid=%b data=%h ovf=%b want 0/0/000/0",
               evt_count, evt_valid, evt_data, overflow);
    end
    ps2_clk = 1'b1;
    repeat (5) tick();
    #2 rst_n = 1'b1;
    m_ext = 0;
    m_rel = 0;
    got_q.delete();
    exp_q.delete();
    evt_ready = 1'b1;
    repeat (3 * Half) tick();
    n_checks++;
    if (evt_valid !== 1'b0 || {parity_err, frame_err, timeout_err} !== 3'b0) begin
      n_fail++;
      $display("FAIL midreset_quiet got valid=%b errs=%b want 0/000",
               evt_valid, {parity_err, frame_err, timeout_err});
    end
    send_frame(8'h5A, 0, 0);
    model_byte(8'h5A, 0, 0);
    n_checks++;
    if (got_q.size() != 1 || got_q[0] !== 10'h05A) begin
      n_fail++;
      $display("FAIL midreset_next got n=%0d first=%h want n=1 data=05a",
               got_q.size(), (got_q.size() > 0) ? got_q[0] : 10'h0);
    end
    got_q.delete();
    exp_q.delete();
  endtask

  initial begin
    test_reset();
    test_single_event();
    test_prefix();
    test_parity();
    test_frame_errors();
    test_timeout();
    test_bat();
    test_random();
    test_overflow();
    test_reset_midframe();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ps2_key_receiver.md
PS2_KEY_RECEIVER -- requirements
Module: ps2_key_receiver

Interface
REQ-001 Parameter FIFO_DEPTH, default 8: event FIFO entries; SHALL be a power of two, >= 2.
REQ-002 Parameter SYNC_STAGES, default 2: synchroniser flops on ps2_clk and ps2_data; SHALL be >= 2.
REQ-003 Parameter FILTER_LEN, default 8: consecutive equal samples needed before the filtered ps2_clk changes.
REQ-004 Parameter TIMEOUT_CYCLES, default 50000: clk cycles allowed between PS/2 falling edges inside a frame.
REQ-005 clk  in  1  system clock; the only clock; all state on its rising edge.
REQ-006 rst_n  in  1  asynchronous, active-low reset.
REQ-007 ps2_clk  in  1  raw keyboard clock, asynchronous to clk.
REQ-008 ps2_data  in  1  raw keyboard data, asynchronous to clk.
REQ-009 evt_data  out  10  FIFO head {extended, release, code[7:0]}.
REQ-010 evt_valid  out  1  FIFO non-empty.
REQ-011 evt_ready  in  1  consumer pop; pop occurs when evt_valid && evt_ready.
REQ-012 evt_count  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.
REQ-013 bat_pass, bat_fail  out  1 each  one-cycle pulses on self-test codes 0xAA / 0xFC.
REQ-014 parity_err, frame_err, timeout_err  out  1 each  one-cycle error pulses.
REQ-015 overflow  out  1  sticky: an event was dropped because the FIFO was full.
REQ-016 overflow_clr  in  1  clears overflow.

Function
REQ-017 Both raw inputs SHALL pass through SYNC_STAGES flops; filtered clock SHALL change only after FILTER_LEN identical synchronised samples.
REQ-018 A PS/2 edge SHALL be a 1->0 transition of the filtered clock; data SHALL be sampled from synchronised ps2_data in that same cycle.
REQ-019 Frame FSM states IDLE, DATA, PARITY, STOP: IDLE->DATA on edge with data=0; DATA collects 8 bits LSB first, ->PARITY after bit 8; PARITY->STOP on next edge; STOP->IDLE on next edge.
REQ-020 Edge in IDLE with data=1: frame_err pulse, FSM remains IDLE.
REQ-021 Odd parity over 8 data bits plus parity bit; on mismatch, parity_err SHALL pulse at the stop edge and the byte SHALL be discarded.
REQ-022 Stop bit = 0: frame_err pulse, byte discarded; if parity also bad, both pulses in the same cycle.
REQ-023 Edge-gap counter resets on every edge; in any state other than IDLE, reaching TIMEOUT_CYCLES SHALL pulse timeout_err and force IDLE.
REQ-024 Any error (parity, frame, timeout) SHALL also clear the pending extended/release flags.
REQ-025 Good byte 0xE0 sets pending extended; 0xF0 sets pending release; neither pushes an event.
REQ-026 Good byte 0xAA or 0xFC with no prefix pending: bat_pass or bat_fail pulse, no event.
REQ-027 Any other good byte, or 0xAA/0xFC with a prefix pending: push {extended, release, code}; clear both flags.
REQ-028 Latency: evt_valid SHALL rise the clk cycle after the stop-bit edge for a push into an empty FIFO; status pulses appear in the stop-edge cycle + 1.
REQ-029 Push when full with no simultaneous pop: event dropped, overflow set, FIFO contents unchanged.
REQ-030 Push and pop in the same cycle when full: both performed, no overflow; when empty: push only, pop ignored.
REQ-031 overflow_clr together with a new overflow in the same cycle: overflow remains set.
REQ-032 Pointers SHALL wrap modulo FIFO_DEPTH; evt_count SHALL never exceed FIFO_DEPTH.

Reset
REQ-033 rst_n low SHALL immediately clear: FSM to IDLE, shift/gap counters, prefix flags, FIFO (evt_count=0, evt_valid=0), overflow, all pulses; filtered clock and synchronisers to 1; evt_data to 0.
REQ-034 Reset released mid-frame: the partial frame SHALL be ignored; the next start bit begins a fresh frame.

Structure
REQ-035 Shared package ps2_pkg SHALL hold constants PS2_BAT_PASS=0xAA, PS2_BAT_FAIL=0xFC, PS2_EXT=0xE0, PS2_REL=0xF0, the frame-state encoding and the 10-bit event field offsets.
REQ-036 One sub-module ps2_event_fifo (parametrised WIDTH, DEPTH, synchronous, same clk and rst_n) SHALL implement the buffer.

Verification
REQ-037 Frame 0x1C, good parity -> one event evt_data=0x01C, evt_valid rises cycle after stop edge.
REQ-038 Bytes E0,F0,75 -> single event 0x375; no event for prefixes.
REQ-039 Byte 0x1C with parity bit inverted -> parity_err pulse, no event; then F0,1C -> event 0x11C (no stale ext).
REQ-040 Stop after 4 data bits, wait TIMEOUT_CYCLES -> timeout_err pulse, FSM IDLE, following 0x29 frame -> event 0x029.
REQ-041 FIFO_DEPTH+1 codes, evt_ready=0 -> evt_count=FIFO_DEPTH, overflow=1, head equals first code; overflow_clr -> 0.
REQ-042 Byte 0xAA -> bat_pass pulse, no event; rst_n asserted mid-frame then released -> all outputs at reset values, next frame decoded.
